// File: rtl/mul_accumulator_if.sv
// Product-stream and result handshake bundle between the multiplier side and the accumulator.
// master = producer/consumer environment, slave = accumulator.
interface mul_accumulator_if #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/mul_accumulator.sv
// Accumulates a last-delimited burst of unsigned products into a guard-bit accumulator
// and holds the sum, beat count and sticky wrap flag until the consumer takes it.
module mul_accumulator #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,  // must be >= PROD_W
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    mul_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               ovf, ovf_nxt;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     sum;
    logic               accept;

    assign prod_ext = ACC_W'(bus.in_prod);
    assign sum      = {1'b0, acc} + {1'b0, prod_ext};

    // No bypass: HOLD blocks input even on the cycle the result is taken.
    assign bus.in_ready  = rst_n & (state != HOLD);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state == HOLD);

    // Result fields read as zero outside HOLD.
    assign bus.out_acc   = bus.out_valid ? acc   : '0;
    assign bus.out_count = bus.out_valid ? count : '0;
    assign bus.out_ovf   = bus.out_valid ? ovf   : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = prod_ext;
                    count_nxt = CNT_W'(1);
                    ovf_nxt   = 1'b0;
                    state_nxt = bus.in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt   = sum[ACC_W-1:0];
                    ovf_nxt   = ovf | sum[ACC_W];
                    // Saturate rather than wrap so long bursts still report a sane count.
                    count_nxt = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
                    state_nxt = bus.in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    acc_nxt   = '0;
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench: default build plus a 64-bit-accumulator build (wrap) and a 2-bit-counter build (saturation).
module tb_mul_accumulator;
    logic clk;
    logic rst_n;
    logic clear;
    int   checks;
    int   errors;

    mul_accumulator_if #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) m_if ();
    mul_accumulator_if #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) o_if ();
    mul_accumulator_if #(.PROD_W(64), .ACC_W(72), .CNT_W(2)) c_if ();

    mul_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) dut_m (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(m_if.slave));
    mul_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) dut_o (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(o_if.slave));
    mul_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(c_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_m(input logic [63:0] p, input logic l);
        m_if.in_valid = 1'b1; m_if.in_prod = p; m_if.in_last = l;
        step();
        m_if.in_valid = 1'b0; m_if.in_prod = '0; m_if.in_last = 1'b0;
    endtask

    task automatic send_o(input logic [63:0] p, input logic l);
        o_if.in_valid = 1'b1; o_if.in_prod = p; o_if.in_last = l;
        step();
        o_if.in_valid = 1'b0; o_if.in_prod = '0; o_if.in_last = 1'b0;
    endtask

    task automatic send_c(input logic [63:0] p, input logic l);
        c_if.in_valid = 1'b1; c_if.in_prod = p; c_if.in_last = l;
        step();
        c_if.in_valid = 1'b0; c_if.in_prod = '0; c_if.in_last = 1'b0;
    endtask

    logic [31:0] wa;
    logic [31:0] wb;
    logic [63:0] wprod;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        m_if.in_valid = 1'b0; m_if.in_prod = '0; m_if.in_last = 1'b0; m_if.out_ready = 1'b0;
        o_if.in_valid = 1'b0; o_if.in_prod = '0; o_if.in_last = 1'b0; o_if.out_ready = 1'b0;
        c_if.in_valid = 1'b0; c_if.in_prod = '0; c_if.in_last = 1'b0; c_if.out_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_in_ready", m_if.in_ready, 0);
        chk("rst_out_valid", m_if.out_valid, 0);
        chk("rst_out_acc", m_if.out_acc, 0);
        chk("rst_out_count", m_if.out_count, 0);
        chk("rst_out_ovf", m_if.out_ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", m_if.in_ready, 1);

        // Reset mid-burst drops the partial sum
        send_m(64'd5, 1'b0);
        send_m(64'd7, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready_low", m_if.in_ready, 0);
        step();
        chk("midrst_out_valid", m_if.out_valid, 0);
        chk("midrst_in_ready_held", m_if.in_ready, 0);
        rst_n = 1'b1;
        #1;
        send_m(64'd3, 1'b1);
        chk("midrst_res_valid", m_if.out_valid, 1);
        chk("midrst_res_acc", m_if.out_acc, 3);
        chk("midrst_res_count", m_if.out_count, 1);
        m_if.out_ready = 1'b1;
        step();
        m_if.out_ready = 1'b0;
        chk("midrst_drained", m_if.out_valid, 0);

        // Basic three-beat burst, continuous valid
        send_m(64'h10, 1'b0);
        send_m(64'h20, 1'b0);
        chk("basic_not_yet_valid", m_if.out_valid, 0);
        chk("basic_acc_masked", m_if.out_acc, 0);
        send_m(64'h30, 1'b1);
        chk("basic_valid", m_if.out_valid, 1);
        chk("basic_acc", m_if.out_acc, 128'h60);
        chk("basic_count", m_if.out_count, 3);
        chk("basic_ovf", m_if.out_ovf, 0);
        m_if.out_ready = 1'b1;
        step();
        m_if.out_ready = 1'b0;

        // Bubbles mid-burst, then backpressure on the result
        send_m(64'd1, 1'b0);
        m_if.in_prod = 64'd100; m_if.in_last = 1'b1;  // ignored: no valid
        step(); step();
        m_if.in_prod = '0; m_if.in_last = 1'b0;
        chk("bubble_no_result", m_if.out_valid, 0);
        send_m(64'd2, 1'b0);
        send_m(64'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", m_if.out_valid, 1);
            chk("bp_acc", m_if.out_acc, 6);
            chk("bp_in_ready", m_if.in_ready, 0);
            step();
        end
        m_if.out_ready = 1'b1;
        #1;
        chk("bp_no_bypass", m_if.in_ready, 0);
        step();
        m_if.out_ready = 1'b0;
        chk("bp_after_in_ready", m_if.in_ready, 1);
        chk("bp_after_out_valid", m_if.out_valid, 0);
        chk("bp_after_acc_zero", m_if.out_acc, 0);

        // Wrap on the 64-bit accumulator build
        send_o(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_o(64'd2, 1'b1);
        chk("ovf_acc", o_if.out_acc, 1);
        chk("ovf_flag", o_if.out_ovf, 1);
        chk("ovf_count", o_if.out_count, 2);
        o_if.out_ready = 1'b1;
        step();
        o_if.out_ready = 1'b0;
        send_o(64'd4, 1'b1);
        chk("ovf_next_flag", o_if.out_ovf, 0);
        chk("ovf_next_acc", o_if.out_acc, 4);
        o_if.out_ready = 1'b1;
        step();
        o_if.out_ready = 1'b0;

        // Guard bits on the default build absorb the same carry
        send_m(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_m(64'd2, 1'b1);
        chk("guard_acc", m_if.out_acc, 128'h1_0000_0000_0000_0001);
        chk("guard_ovf", m_if.out_ovf, 0);
        m_if.out_ready = 1'b1;
        step();
        m_if.out_ready = 1'b0;

        // Count saturation on the 2-bit counter build
        for (int i = 0; i < 4; i++) send_c(64'd1, 1'b0);
        send_c(64'd1, 1'b1);
        chk("sat_count", c_if.out_count, 3);
        chk("sat_acc", c_if.out_acc, 5);
        c_if.out_ready = 1'b1;
        step();
        c_if.out_ready = 1'b0;

        // Clear during ACCUM drops the burst and the beat presented with it
        send_m(64'd9, 1'b0);
        send_m(64'd9, 1'b0);
        m_if.in_valid = 1'b1; m_if.in_prod = 64'd100; m_if.in_last = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        m_if.in_valid = 1'b0; m_if.in_prod = '0; m_if.in_last = 1'b0;
        chk("clr_out_valid", m_if.out_valid, 0);
        chk("clr_in_ready", m_if.in_ready, 1);

        // End-to-end single beat from the multiplier: 0xFFFF_FFFF * 2
        wa = 32'hFFFF_FFFF;
        wb = 32'd2;
        wprod = 64'(wa) * 64'(wb);
        send_m(wprod, 1'b1);
        chk("e2e_acc", m_if.out_acc, 128'h1_FFFF_FFFE);
        chk("e2e_count", m_if.out_count, 1);
        chk("e2e_ovf", m_if.out_ovf, 0);

        // Clear also drops a held result
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_hold_valid", m_if.out_valid, 0);
        chk("clr_hold_acc", m_if.out_acc, 0);
        chk("clr_hold_in_ready", m_if.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
